// File: rtl/controller_pkg.sv
// Shared I3C target-controller definitions: ENTDAA identity widths, the
// ENTDAA ID transmitter state encoding and the identity struct.
package controller_pkg;

    localparam int unsigned ENTDAA_ID_W  = 48;
    localparam int unsigned ENTDAA_BCR_W = 8;
    localparam int unsigned ENTDAA_DCR_W = 8;
    localparam int unsigned ENTDAA_BITS  = ENTDAA_ID_W + ENTDAA_BCR_W + ENTDAA_DCR_W;
    localparam int unsigned ENTDAA_CNT_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SHIFT,
        ST_WON,
        ST_LOST
    } state_e;

    typedef struct packed {
        logic [ENTDAA_ID_W-1:0]  pid;
        logic [ENTDAA_BCR_W-1:0] bcr;
        logic [ENTDAA_DCR_W-1:0] dcr;
    } entdaa_ident_t;

endpackage

// File: rtl/ccc_entdaa_id_tx.sv
// ENTDAA arbitration transmitter: shifts the 64-bit identity out MSB-first in
// open-drain mode and reports completion, lost arbitration or bus abort.
module ccc_entdaa_id_tx
    import controller_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [47:0] id_i,
    input  logic [7:0]  bcr_i,
    input  logic [7:0]  dcr_i,
    output logic        bus_tx_req_bit_o,
    output logic        bus_tx_req_value_o,
    output logic        bus_tx_sel_od_pp_o,
    input  logic        bus_tx_done_i,
    input  logic        sda_sampled_i,
    input  logic        bus_stop_det_i,
    input  logic        bus_rstart_det_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        arbitration_lost_o,
    output logic        bus_error_o,
    output logic        abort_o,
    output logic [6:0]  bit_cnt_o
);

    state_e                  state_q, state_d;
    logic [ENTDAA_BITS-1:0]  shift_q;
    logic [ENTDAA_CNT_W-1:0] bit_cnt_q;
    logic                    lost_q, err_q, abort_q;

    logic          bus_evt, cur_bit;
    logic          load, shift_en, cnt_inc, set_lost, set_err, abort_d;
    entdaa_ident_t ident;

    assign bus_evt = bus_stop_det_i | bus_rstart_det_i;
    assign cur_bit = shift_q[ENTDAA_BITS-1];
    assign ident   = '{pid: id_i, bcr: bcr_i, dcr: dcr_i};

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        cnt_inc  = 1'b0;
        set_lost = 1'b0;
        set_err  = 1'b0;
        abort_d  = 1'b0;
        // STOP/Sr pre-empts everything, including a coincident bit completion
        if (state_q != ST_IDLE && bus_evt) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && !bus_evt) begin
                        load    = 1'b1;
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (bus_tx_done_i) begin
                        if (cur_bit && !sda_sampled_i) begin
                            set_lost = 1'b1;
                            state_d  = ST_LOST;
                        end else if (!cur_bit && sda_sampled_i) begin
                            set_lost = 1'b1;
                            set_err  = 1'b1;
                            state_d  = ST_LOST;
                        end else begin
                            cnt_inc = 1'b1;
                            state_d = (bit_cnt_q == ENTDAA_CNT_W'(ENTDAA_BITS - 1))
                                      ? ST_WON : ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    shift_en = 1'b1;
                    state_d  = ST_DRIVE;
                end
                ST_WON:  state_d = ST_IDLE;
                ST_LOST: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            lost_q    <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            if (load) begin
                shift_q   <= ident;
                bit_cnt_q <= '0;
                lost_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                if (shift_en) shift_q   <= {shift_q[ENTDAA_BITS-2:0], 1'b1};
                if (cnt_inc)  bit_cnt_q <= bit_cnt_q + 1'b1;
                if (set_lost) lost_q    <= 1'b1;
                if (set_err)  err_q     <= 1'b1;
            end
        end
    end

    // Value is gated by the request so every output reads 0 out of reset
    assign bus_tx_req_bit_o   = (state_q == ST_DRIVE);
    assign bus_tx_req_value_o = (state_q == ST_DRIVE) & cur_bit;
    assign bus_tx_sel_od_pp_o = 1'b0;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_WON) & ~bus_evt;
    assign arbitration_lost_o = lost_q;
    assign bus_error_o        = err_q;
    assign abort_o            = abort_q;
    assign bit_cnt_o          = bit_cnt_q;

endmodule

// File: tb/tb_ccc_entdaa_id_tx.sv
// Directed self-checking bench for ccc_entdaa_id_tx: plays the TX engine and
// bus monitor, checking every handshake bit and status output.
module tb_ccc_entdaa_id_tx;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [47:0] id_i = '0;
    logic [7:0]  bcr_i = '0;
    logic [7:0]  dcr_i = '0;
    logic        bus_tx_req_bit_o, bus_tx_req_value_o, bus_tx_sel_od_pp_o;
    logic        bus_tx_done_i = 1'b0;
    logic        sda_sampled_i = 1'b0;
    logic        bus_stop_det_i = 1'b0;
    logic        bus_rstart_det_i = 1'b0;
    logic        busy_o, done_o, arbitration_lost_o, bus_error_o, abort_o;
    logic [6:0]  bit_cnt_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk_i = ~clk_i;

    ccc_entdaa_id_tx dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .start_i            (start_i),
        .id_i               (id_i),
        .bcr_i              (bcr_i),
        .dcr_i              (dcr_i),
        .bus_tx_req_bit_o   (bus_tx_req_bit_o),
        .bus_tx_req_value_o (bus_tx_req_value_o),
        .bus_tx_sel_od_pp_o (bus_tx_sel_od_pp_o),
        .bus_tx_done_i      (bus_tx_done_i),
        .sda_sampled_i      (sda_sampled_i),
        .bus_stop_det_i     (bus_stop_det_i),
        .bus_rstart_det_i   (bus_rstart_det_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .arbitration_lost_o (arbitration_lost_o),
        .bus_error_o        (bus_error_o),
        .abort_o            (abort_o),
        .bit_cnt_o          (bit_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a bit request, checks its value, holds it for
    // 'hold' extra cycles, then completes the bit with the given SDA/STOP.
    task automatic do_bit(input string tag, input logic exp_v, input logic sda,
                          input logic stop, input int hold);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus_tx_req_bit_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        chk({tag, "_req"}, 64'(ok), 64'd1);
        chk({tag, "_val"}, 64'(bus_tx_req_value_o), 64'(exp_v));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk_i);
            chk({tag, "_hold"}, {62'd0, bus_tx_req_bit_o, bus_tx_req_value_o},
                {62'd0, 1'b1, exp_v});
        end
        bus_tx_done_i  = 1'b1;
        sda_sampled_i  = sda;
        bus_stop_det_i = stop;
        @(negedge clk_i);
        bus_tx_done_i  = 1'b0;
        sda_sampled_i  = 1'b0;
        bus_stop_det_i = 1'b0;
    endtask

    task automatic start_xfer(input logic [47:0] id, input logic [7:0] bcr, input logic [7:0] dcr);
        id_i    = id;
        bcr_i   = bcr;
        dcr_i   = dcr;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    logic [63:0] e;

    initial begin
        // Reset values
        repeat (3) @(negedge clk_i);
        chk("rst_req", 64'(bus_tx_req_bit_o), 64'd0);
        chk("rst_val", 64'(bus_tx_req_value_o), 64'd0);
        chk("rst_sel", 64'(bus_tx_sel_od_pp_o), 64'd0);
        chk("rst_flags", {59'd0, busy_o, done_o, arbitration_lost_o, bus_error_o, abort_o}, 64'd0);
        chk("rst_cnt", 64'(bit_cnt_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_busy", 64'(busy_o), 64'd0);

        // Uncontested: echo every bit, varying the Drive length
        e = 64'h0123_4567_89AB_21C3;
        start_xfer(48'h0123_4567_89AB, 8'h21, 8'hC3);
        chk("unc_first_req", 64'(bus_tx_req_bit_o), 64'd1);
        for (int i = 0; i < 64; i++) begin
            do_bit("unc", e[63-i], e[63-i], 1'b0, i % 3);
            if (i < 63) begin
                chk("unc_gap", 64'(bus_tx_req_bit_o), 64'd0);
                chk("unc_nodone", 64'(done_o), 64'd0);
                @(negedge clk_i);
            end
        end
        chk("unc_done", 64'(done_o), 64'd1);
        chk("unc_cnt", 64'(bit_cnt_o), 64'd64);
        chk("unc_lost", 64'(arbitration_lost_o), 64'd0);
        chk("unc_busy_won", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        chk("unc_done_pulse", 64'(done_o), 64'd0);
        chk("unc_busy_end", 64'(busy_o), 64'd0);

        // Loss on the 5th bit
        start_xfer(48'hFFFF_FFFF_FFFF, 8'hA5, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            do_bit("loss_pre", 1'b1, 1'b1, 1'b0, 0);
            @(negedge clk_i);
        end
        do_bit("loss_bit5", 1'b1, 1'b0, 1'b0, 0);
        chk("loss_lost", 64'(arbitration_lost_o), 64'd1);
        chk("loss_cnt", 64'(bit_cnt_o), 64'd4);
        chk("loss_err", 64'(bus_error_o), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("loss_noreq", {62'd0, bus_tx_req_bit_o, done_o}, 64'd0);
            @(negedge clk_i);
        end
        chk("loss_busy", 64'(busy_o), 64'd0);
        chk("loss_lost_hold", 64'(arbitration_lost_o), 64'd1);

        // Bus error: drove 0, sampled 1; start also clears the previous loss
        start_xfer(48'h0, 8'h00, 8'h00);
        chk("berr_clr_lost", 64'(arbitration_lost_o), 64'd0);
        do_bit("berr_bit", 1'b0, 1'b1, 1'b0, 0);
        chk("berr_err", 64'(bus_error_o), 64'd1);
        chk("berr_lost", 64'(arbitration_lost_o), 64'd1);
        chk("berr_cnt", 64'(bit_cnt_o), 64'd0);
        @(negedge clk_i);

        // Restart after loss, ignored start while busy, STOP with 20th done
        e = 64'hA123_4567_89AB_21C3;
        start_xfer(48'hA123_4567_89AB, 8'h21, 8'hC3);
        chk("rs_clr", {62'd0, arbitration_lost_o, bus_error_o}, 64'd0);
        chk("rs_first", {62'd0, bus_tx_req_bit_o, bus_tx_req_value_o}, 64'd3);
        start_xfer(48'hFFFF_FFFF_FFFF, 8'hFF, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            do_bit("rs", e[63-i], e[63-i], (i == 19), 0);
            if (i < 19) @(negedge clk_i);
        end
        chk("stop_abort", 64'(abort_o), 64'd1);
        chk("stop_busy", 64'(busy_o), 64'd0);
        chk("stop_cnt", 64'(bit_cnt_o), 64'd19);
        chk("stop_done", 64'(done_o), 64'd0);
        @(negedge clk_i);
        chk("stop_abort_pulse", 64'(abort_o), 64'd0);
        chk("stop_cnt_hold", 64'(bit_cnt_o), 64'd19);

        // STOP coincident with start in Idle: start ignored
        bus_stop_det_i = 1'b1;
        start_xfer(48'h1234_5678_9ABC, 8'h00, 8'h00);
        bus_stop_det_i = 1'b0;
        chk("stopidle_busy", 64'(busy_o), 64'd0);
        chk("stopidle_req", 64'(bus_tx_req_bit_o), 64'd0);
        chk("stopidle_abort", 64'(abort_o), 64'd0);
        chk("stopidle_cnt", 64'(bit_cnt_o), 64'd19);

        // Asynchronous reset during Drive
        e = 64'h0123_4567_89AB_21C3;
        start_xfer(48'h0123_4567_89AB, 8'h21, 8'hC3);
        do_bit("rstm", e[63], e[63], 1'b0, 0);
        @(negedge clk_i);
        do_bit("rstm", e[62], e[62], 1'b0, 0);
        @(negedge clk_i);
        chk("rstm_drive", 64'(bus_tx_req_bit_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rstm_req", 64'(bus_tx_req_bit_o), 64'd0);
        chk("rstm_flags", {59'd0, busy_o, done_o, arbitration_lost_o, bus_error_o, abort_o}, 64'd0);
        chk("rstm_cnt", 64'(bit_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            chk("rstm_idle", {62'd0, busy_o, bus_tx_req_bit_o}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
